// File: rtl/alu_pkg.sv
// Shared types and control words for the Hack ALU and the multiply sequencer.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DBL  = 2'd2,
      DONE = 2'd3
   } mul_state_t;

   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_ctrl_t;

   localparam alu_ctrl_t ALU_CTRL_ADD   = 6'b000010;
   localparam alu_ctrl_t ALU_CTRL_PASSX = 6'b001010;
   localparam alu_ctrl_t ALU_CTRL_ZERO  = 6'b101010;

endpackage

// File: rtl/alu.sv
// Hack ALU: combinational zero/negate preprocessing, add-or-and, optional output negate.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  alu_ctrl_t        ctrl,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng
);

   logic [WIDTH-1:0] x_z_s, x_n_s, y_z_s, y_n_s, f_s;

   // Operand conditioning, function select and flag generation.
   always_comb begin
      x_z_s = ctrl.zx ? {WIDTH{1'b0}} : x;
      x_n_s = ctrl.nx ? ~x_z_s : x_z_s;
      y_z_s = ctrl.zy ? {WIDTH{1'b0}} : y;
      y_n_s = ctrl.ny ? ~y_z_s : y_z_s;
      f_s   = ctrl.f ? (x_n_s + y_n_s) : (x_n_s & y_n_s);
      out   = ctrl.no ? ~f_s : f_s;
      zr    = (out == {WIDTH{1'b0}});
      ng    = out[WIDTH-1];
   end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16-bit multiplier that issues every add/doubling through one Hack ALU.
// Optional macro ALU_MUL_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_prod,
   output logic             resp_zr,
   output logic             resp_ng,
   output logic             busy
);

   mul_state_t       state_r, state_nxt_s;
   logic [WIDTH-1:0] acc_r, m_r, q_r;
   logic [3:0]       idx_r;
   logic             zr_r, ng_r;
   logic             last_s;

   alu_ctrl_t        ctrl_s;
   logic [WIDTH-1:0] alu_x_s, alu_y_s, alu_out_s;
   logic             alu_zr_s, alu_ng_s;

   alu #(.WIDTH(WIDTH)) u_alu (
      .x    (alu_x_s),
      .y    (alu_y_s),
      .ctrl (ctrl_s),
      .out  (alu_out_s),
      .zr   (alu_zr_s),
      .ng   (alu_ng_s)
   );

   // Detect the final ADD of an operation.
   always_comb begin
`ifdef ALU_MUL_EARLY_EXIT_EN
      last_s = (idx_r == 4'd15) ||
               ((q_r >> ({1'b0, idx_r} + 5'd1)) == {WIDTH{1'b0}});
`else
      last_s = (idx_r == 4'd15);
`endif
   end

   // ALU operand/control steering and next-state decode.
   always_comb begin
      alu_x_s     = acc_r;
      alu_y_s     = m_r;
      ctrl_s      = ALU_CTRL_ZERO;
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               state_nxt_s = ADD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ADD: begin
            ctrl_s      = q_r[idx_r] ? ALU_CTRL_ADD : ALU_CTRL_PASSX;
            state_nxt_s = last_s ? DONE : DBL;
         end
         DBL: begin
            alu_x_s     = m_r;
            alu_y_s     = m_r;
            ctrl_s      = ALU_CTRL_ADD;
            state_nxt_s = ADD;
         end
         DONE: begin
            if (resp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Datapath and state registers; flags latch on every ADD so the last one survives into DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         acc_r   <= {WIDTH{1'b0}};
         m_r     <= {WIDTH{1'b0}};
         q_r     <= {WIDTH{1'b0}};
         idx_r   <= 4'd0;
         zr_r    <= 1'b1;
         ng_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  acc_r <= {WIDTH{1'b0}};
                  m_r   <= req_a;
                  q_r   <= req_b;
                  idx_r <= 4'd0;
               end
            end
            ADD: begin
               acc_r <= alu_out_s;
               zr_r  <= alu_zr_s;
               ng_r  <= alu_ng_s;
            end
            DBL: begin
               m_r   <= alu_out_s;
               idx_r <= idx_r + 4'd1;
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

   assign req_ready  = (state_r == IDLE);
   assign resp_valid = (state_r == DONE);
   assign busy       = (state_r != IDLE);
   assign resp_prod  = acc_r;
   assign resp_zr    = zr_r;
   assign resp_ng    = ng_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed plus random bench for alu_mul_seq with an expected-result queue.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_a, req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_prod;
   logic        resp_zr, resp_ng, busy;

   typedef struct {
      logic [15:0] prod;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   alu_mul_seq #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_prod  (resp_prod),
      .resp_zr    (resp_zr),
      .resp_ng    (resp_ng),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int model_lat(input logic [15:0] b);
      int msb;
`ifdef ALU_MUL_EARLY_EXIT_EN
      msb = 0;
      for (int i = 0; i < 16; i++) begin
         if (b[i]) msb = i;
      end
      return 2 * msb + 1;
`else
      msb = 15;
      return 2 * msb + 1;
`endif
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_prod"}, {16'd0, resp_prod}, 32'd0);
      check({tag, "_zr"}, {31'd0, resp_zr}, 32'd1);
      check({tag, "_ng"}, {31'd0, resp_ng}, 32'd0);
   endtask

   // One full transaction; optionally stalls and presents a competing request while stalled.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stall, input bit hold);
      exp_t e;
      exp_t got;
      int   lat;
      logic [31:0] full;
      @(negedge clk);
      req_a = a;
      req_b = b;
      req_valid = 1'b1;
      check("accept_ready", {31'd0, req_ready}, 32'd1);
      full   = {16'd0, a} * {16'd0, b};
      e.prod = full[15:0];
      e.lat  = model_lat(b);
      exp_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (resp_valid) begin
            lat = n;
            break;
         end
      end
      if (lat == 0) begin
         check("resp_timeout", 32'd0, 32'd1);
         void'(exp_q.pop_front());
         return;
      end
      got = exp_q.pop_front();
      check("latency", lat, got.lat);
      check("prod", {16'd0, resp_prod}, {16'd0, got.prod});
      check("zr", {31'd0, resp_zr}, {31'd0, (got.prod == 16'd0)});
      check("ng", {31'd0, resp_ng}, {31'd0, got.prod[15]});
      resp_ready = 1'b0;
      if (hold) begin
         req_valid = 1'b1;
         req_a = 16'h1111;
         req_b = 16'h0002;
      end
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         check("stall_valid", {31'd0, resp_valid}, 32'd1);
         check("stall_prod", {16'd0, resp_prod}, {16'd0, got.prod});
         if (hold) check("stall_no_ready", {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      check("once_valid_low", {31'd0, resp_valid}, 32'd0);
      check("back_idle_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_a = 16'd0;
      req_b = 16'd0;
      resp_ready = 1'b0;
      #12;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Abort an operation mid-flight; nothing may be delivered for it.
      @(negedge clk);
      req_a = 16'd100;
      req_b = 16'd200;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'd7, 16'd9, 0, 1'b0);

      run_op(16'd3, 16'd5, 2, 1'b0);
      run_op(16'hFFFF, 16'd2, 0, 1'b0);
      run_op(16'h8000, 16'd2, 1, 1'b0);
      run_op(16'd1234, 16'd0, 0, 1'b0);
      run_op(16'd1234, 16'd1, 0, 1'b0);
      run_op(16'd3, 16'd5, 10, 1'b1);
      run_op(16'h1111, 16'h0002, 0, 1'b0);

      for (int k = 0; k < 200; k++) begin
         run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0);
      end

      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
